// File: rtl/masked_mem_rmw_arbiter_if.sv
// Purpose: bundles the two requester channels, the shared response and the
//          single-port memory bus of masked_mem_rmw_arbiter.
// Ports (signals):
//   rX_req/rX_wr/rX_addr/rX_wdata/rX_mask  requester command, X = 0/1
//   rX_gnt/rX_done                         per-requester handshake pulses
//   rdata/busy                             shared response word and busy flag
//   mem_en/mem_wr/mem_addr/mem_wdata       memory command
//   mem_rdata                              memory read data (1-cycle latency)
// Modports: slave = arbiter side, master = clients + memory side.
interface masked_mem_rmw_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
);
    logic          r0_req;
    logic          r0_wr;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic [DW-1:0] r0_mask;
    logic          r0_gnt;
    logic          r0_done;

    logic          r1_req;
    logic          r1_wr;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic [DW-1:0] r1_mask;
    logic          r1_gnt;
    logic          r1_done;

    logic [DW-1:0] rdata;
    logic          busy;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  r0_req, r0_wr, r0_addr, r0_wdata, r0_mask,
        input  r1_req, r1_wr, r1_addr, r1_wdata, r1_mask,
        input  mem_rdata,
        output r0_gnt, r0_done, r1_gnt, r1_done,
        output rdata, busy,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output r0_req, r0_wr, r0_addr, r0_wdata, r0_mask,
        output r1_req, r1_wr, r1_addr, r1_wdata, r1_mask,
        output mem_rdata,
        input  r0_gnt, r0_done, r1_gnt, r1_done,
        input  rdata, busy,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/masked_mem_rmw_arbiter.sv
// Purpose: round-robin two-requester controller in front of a single-port
//          memory with 1-cycle read latency. Every access reads the old word;
//          writes then store (old & ~mask) | (wdata & mask).
// Ports:
//   clk    clock, posedge
//   rst_n  synchronous active-low reset
//   bus    masked_mem_rmw_arbiter_if.slave (requesters, response, memory)
module masked_mem_rmw_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    masked_mem_rmw_arbiter_if.slave       bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mask;
    } cmd_t;

    state_t        r_state;
    state_t        w_state_nxt;
    cmd_t          r_cmd;
    cmd_t          w_cmd;
    logic          r_owner;     // requester being served
    logic          r_last;      // last requester granted
    logic [DW-1:0] r_old_word;
    logic          w_pick1;
    logic          w_grant;

    // Arbitration: a lone request wins; on a tie the one not served last wins.
    always_comb begin
        w_pick1 = bus.r1_req & (~bus.r0_req | ~r_last);
        w_grant = (r_state == S_IDLE) & (bus.r0_req | bus.r1_req) & rst_n;
        if (w_pick1) begin
            w_cmd = '{wr: bus.r1_wr, addr: bus.r1_addr, wdata: bus.r1_wdata, mask: bus.r1_mask};
        end else begin
            w_cmd = '{wr: bus.r0_wr, addr: bus.r0_addr, wdata: bus.r0_wdata, mask: bus.r0_mask};
        end
    end

    // State register, command latch and read capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_old_word <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_cmd   <= w_cmd;
                r_owner <= w_pick1;
                r_last  <= w_pick1;
            end
            if (r_state == S_CAP) begin
                r_old_word <= bus.mem_rdata;
            end
        end
    end

    // Next state and state-decoded outputs; strobes are gated by rst_n so a
    // reset cycle never issues a grant, a done or a memory access.
    always_comb begin
        w_state_nxt   = r_state;
        bus.r0_gnt    = 1'b0;
        bus.r1_gnt    = 1'b0;
        bus.r0_done   = 1'b0;
        bus.r1_done   = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.busy      = (r_state != S_IDLE);
        bus.rdata     = r_old_word;
        bus.mem_addr  = r_cmd.addr;
        bus.mem_wdata = (r_old_word & ~r_cmd.mask) | (r_cmd.wdata & r_cmd.mask);

        case (r_state)
            S_IDLE: begin
                bus.r0_gnt = w_grant & ~w_pick1;
                bus.r1_gnt = w_grant & w_pick1;
                if (w_grant) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                bus.mem_en  = rst_n;
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                w_state_nxt = r_cmd.wr ? S_WR : S_RESP;
            end
            S_WR: begin
                bus.mem_en  = rst_n;
                bus.mem_wr  = rst_n;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.r0_done = rst_n & ~r_owner;
                bus.r1_done = rst_n & r_owner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_masked_mem_rmw_arbiter.sv
// Purpose: directed self-checking bench for masked_mem_rmw_arbiter with a
//          behavioural 1-cycle-latency memory.
module tb_masked_mem_rmw_arbiter;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    masked_mem_rmw_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

    masked_mem_rmw_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Memory model with a side port for preloading words.
    logic [DW-1:0] mem [0:255];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (bus_if.mem_en && !bus_if.mem_wr) bus_if.mem_rdata <= mem[bus_if.mem_addr];
        if (bus_if.mem_en && bus_if.mem_wr) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Protocol invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_excl", 32'(bus_if.r0_gnt & bus_if.r1_gnt), 32'd0);
            check("done_excl", 32'(bus_if.r0_done & bus_if.r1_done), 32'd0);
            check("gnt_busy", 32'((bus_if.r0_gnt | bus_if.r1_gnt) & bus_if.busy), 32'd0);
        end
    end

    task automatic set_req(input bit who, input bit req, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        if (who) begin
            bus_if.r1_req = req; bus_if.r1_wr = wr; bus_if.r1_addr = a;
            bus_if.r1_wdata = d; bus_if.r1_mask = m;
        end else begin
            bus_if.r0_req = req; bus_if.r0_wr = wr; bus_if.r0_addr = a;
            bus_if.r0_wdata = d; bus_if.r0_mask = m;
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // One full access: request, wait for grant, check latency, strobe and rdata.
    task automatic access(input string tag, input bit who, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m,
                          input logic [DW-1:0] exp_rdata, input logic [DW-1:0] exp_wdata);
        bit got;
        int k;
        int wr_k;
        logic [DW-1:0] wd;
        @(posedge clk); #1;
        set_req(who, 1'b1, wr, a, d, m);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = who ? bus_if.r1_gnt : bus_if.r0_gnt;
        end
        check({tag, "_gnt"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        set_req(who, 1'b0, 1'b0, '0, '0, '0);
        k = 0; wr_k = 0; wd = '0; got = 1'b0;
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            if (bus_if.mem_en && bus_if.mem_wr) begin
                wr_k = k;
                wd   = bus_if.mem_wdata;
            end
            got = who ? bus_if.r1_done : bus_if.r0_done;
        end
        check({tag, "_done_lat"}, 32'(k), wr ? 32'd4 : 32'd3);
        check({tag, "_wr_cyc"}, 32'(wr_k), wr ? 32'd3 : 32'd0);
        check({tag, "_rdata"}, bus_if.rdata, exp_rdata);
        if (wr) check({tag, "_wdata"}, wd, exp_wdata);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int g_who [4];
        int g_cyc [4];
        int n_g;
        int cyc;
        bit seen;

        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        bus_if.mem_rdata = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_mem_en", 32'(bus_if.mem_en), 32'd0);
        check("rst_mem_wr", 32'(bus_if.mem_wr), 32'd0);
        check("rst_gnt", 32'({bus_if.r0_gnt, bus_if.r1_gnt}), 32'd0);
        check("rst_done", 32'({bus_if.r0_done, bus_if.r1_done}), 32'd0);
        check("rst_rdata", bus_if.rdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        preload(8'd5, 32'h0000_0000);
        preload(8'd3, 32'h1234_5678);
        preload(8'd7, 32'h0000_0000);

        // Full write then read-back.
        access("t1_wr", 1'b0, 1'b1, 8'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF);
        access("t1_rd", 1'b0, 1'b0, 8'd5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0);

        // Partial mask write returns old word; unmasked bits preserved.
        access("t2_wr", 1'b1, 1'b1, 8'd5, 32'h0000_0000, 32'h0000_FF00, 32'hFFFF_FFFF, 32'hFFFF_00FF);
        access("t2_rd", 1'b1, 1'b0, 8'd5, 32'h0, 32'h0, 32'hFFFF_00FF, 32'h0);

        // Both requesters held high after reset: strict alternation, r0 first.
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 8'd5, '0, '0);
        set_req(1'b1, 1'b1, 1'b0, 8'd5, '0, '0);
        n_g = 0;
        for (int c = 0; c < 40 && n_g < 4; c++) begin
            @(negedge clk);
            if (bus_if.r0_gnt || bus_if.r1_gnt) begin
                g_who[n_g] = bus_if.r1_gnt ? 1 : 0;
                g_cyc[n_g] = c;
                n_g++;
            end
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("t3_ngnt", 32'(n_g), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_g) begin
                check($sformatf("t3_who%0d", i), 32'(g_who[i]), 32'(i % 2));
                if (i > 0) check($sformatf("t3_gap%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd4);
            end
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = !bus_if.busy;
        end
        check("t3_idle", 32'(seen), 32'd1);

        // r1 requests during r0's RD; granted only the cycle after r0_done.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 8'd5, '0, '0);
        @(negedge clk);
        check("t4_gnt0", 32'(bus_if.r0_gnt), 32'd1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b1, 1'b0, 8'd3, '0, '0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("t4_nogrant_c%0d", c), 32'(bus_if.r1_gnt), 32'd0);
        end
        check("t4_done0", 32'(bus_if.r0_done), 32'd1);
        @(negedge clk);
        check("t4_gnt1", 32'(bus_if.r1_gnt), 32'd1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            seen = bus_if.r1_done;
        end
        check("t4_done1_lat", 32'(cyc), 32'd3);
        check("t4_rdata", bus_if.rdata, 32'h1234_5678);

        // Zero mask still writes, with the old word unchanged.
        access("t5_wr", 1'b0, 1'b1, 8'd3, 32'hDEAD_BEEF, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678);
        check("t5_mem", mem[3], 32'h1234_5678);

        // Reset during CAP of a write: access abandoned.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 8'd7, 32'hAAAA_5555, 32'hFFFF_FFFF);
        @(negedge clk);
        check("t6_gnt", 32'(bus_if.r0_gnt), 32'd1);
        @(posedge clk); #1;                       // RD
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1 rst_n = 1'b0;          // CAP with reset low
        @(negedge clk);
        check("t6_cap_wr", 32'(bus_if.mem_wr), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(bus_if.busy), 32'd0);
        check("t6_mem_en", 32'(bus_if.mem_en), 32'd0);
        check("t6_done", 32'({bus_if.r0_done, bus_if.r1_done}), 32'd0);
        check("t6_rdata", bus_if.rdata, 32'd0);
        repeat (2) @(negedge clk);
        check("t6_mem", mem[7], 32'h0000_0000);
        access("t6_rd", 1'b1, 1'b0, 8'd7, 32'h0, 32'h0, 32'h0000_0000, 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
